// File: rtl/ht_res_collector.sv
// rtl/ht_res_collector.sv - result FIFO with valid/ready output and saturating per-rescode statistics
// Buffers hash table results for a slow consumer and counts accepted results by result code.

module ht_res_collector #(
    parameter int KEY_WIDTH    = 32,
    parameter int VALUE_WIDTH  = 32,
    parameter int BUCKET_WIDTH = 10,
    parameter int DEPTH        = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       res_in_valid_i,
    output logic                       res_in_ready_o,
    input  logic [KEY_WIDTH-1:0]       res_in_key_i,
    input  logic [VALUE_WIDTH-1:0]     res_in_value_i,
    input  logic [1:0]                 res_in_opcode_i,
    input  logic [2:0]                 res_in_rescode_i,
    input  logic [BUCKET_WIDTH-1:0]    res_in_bucket_i,
    input  logic [VALUE_WIDTH-1:0]     res_in_found_value_i,
    input  logic [2:0]                 res_in_chain_state_i,
    output logic                       res_out_valid_o,
    input  logic                       res_out_ready_i,
    output logic [KEY_WIDTH-1:0]       res_out_key_o,
    output logic [VALUE_WIDTH-1:0]     res_out_value_o,
    output logic [1:0]                 res_out_opcode_o,
    output logic [2:0]                 res_out_rescode_o,
    output logic [BUCKET_WIDTH-1:0]    res_out_bucket_o,
    output logic [VALUE_WIDTH-1:0]     res_out_found_value_o,
    output logic [2:0]                 res_out_chain_state_o,
    output logic [$clog2(DEPTH):0]     level_o,
    input  logic [2:0]                 stat_sel_i,
    output logic [CNT_WIDTH-1:0]       stat_cnt_o,
    output logic [CNT_WIDTH-1:0]       stat_total_o,
    input  logic                       stat_clear_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int PAY_W = KEY_WIDTH + 2 * VALUE_WIDTH + 2 + 3 + BUCKET_WIDTH + 3;

    logic [PAY_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic [CNT_WIDTH-1:0] cnt [8];
    logic [CNT_WIDTH-1:0] total;
    logic                 push;
    logic                 pop;

    // Flow control depends only on the registered level, never on res_out_ready_i.
    assign res_in_ready_o  = (level != LVL_W'(DEPTH));
    assign res_out_valid_o = (level != '0);
    assign push            = res_in_valid_i && res_in_ready_o;
    assign pop             = res_out_valid_o && res_out_ready_i;
    assign level_o         = level;
    assign stat_total_o    = total;

    assign {res_out_key_o, res_out_value_o, res_out_opcode_o, res_out_rescode_o,
            res_out_bucket_o, res_out_found_value_o, res_out_chain_state_o} = mem[rd_ptr];

    // Payload storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {res_in_key_i, res_in_value_i, res_in_opcode_i, res_in_rescode_i,
                            res_in_bucket_i, res_in_found_value_i, res_in_chain_state_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Clear takes priority over counting a push in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || stat_clear_i) begin
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
            total <= '0;
        end else if (push) begin
            if (cnt[res_in_rescode_i] != '1) cnt[res_in_rescode_i] <= cnt[res_in_rescode_i] + CNT_WIDTH'(1);
            if (total != '1) total <= total + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) stat_cnt_o <= '0;
        else       stat_cnt_o <= cnt[stat_sel_i];
    end

endmodule

// File: tb/tb_ht_res_collector.sv
// tb/tb_ht_res_collector.sv - randomized and directed checks of ht_res_collector against a queue model
module tb_ht_res_collector;

    localparam int DEPTH = 16;
    localparam int CNTW  = 4;
    localparam int CMAX  = (1 << CNTW) - 1;

    typedef struct packed {
        logic [31:0] key;
        logic [31:0] value;
        logic [1:0]  opcode;
        logic [2:0]  rescode;
        logic [9:0]  bucket;
        logic [31:0] found;
        logic [2:0]  chain;
    } res_t;

    logic clk = 0;
    logic rst = 0;
    logic in_valid = 0;
    logic in_ready;
    logic [31:0] in_key = 0, in_value = 0, in_found = 0;
    logic [1:0]  in_opcode = 0;
    logic [2:0]  in_rescode = 0, in_chain = 0;
    logic [9:0]  in_bucket = 0;
    logic out_valid;
    logic out_ready = 0;
    logic [31:0] out_key, out_value, out_found;
    logic [1:0]  out_opcode;
    logic [2:0]  out_rescode, out_chain;
    logic [9:0]  out_bucket;
    logic [4:0]  level;
    logic [2:0]  stat_sel = 0;
    logic [CNTW-1:0] stat_cnt, stat_total;
    logic stat_clear = 0;

    res_t q[$];
    int unsigned cnt_m[8];
    int unsigned tot_m;
    int unsigned stat_exp;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ht_res_collector #(
        .KEY_WIDTH(32), .VALUE_WIDTH(32), .BUCKET_WIDTH(10), .DEPTH(DEPTH), .CNT_WIDTH(CNTW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .res_in_valid_i(in_valid), .res_in_ready_o(in_ready),
        .res_in_key_i(in_key), .res_in_value_i(in_value), .res_in_opcode_i(in_opcode),
        .res_in_rescode_i(in_rescode), .res_in_bucket_i(in_bucket),
        .res_in_found_value_i(in_found), .res_in_chain_state_i(in_chain),
        .res_out_valid_o(out_valid), .res_out_ready_i(out_ready),
        .res_out_key_o(out_key), .res_out_value_o(out_value), .res_out_opcode_o(out_opcode),
        .res_out_rescode_o(out_rescode), .res_out_bucket_o(out_bucket),
        .res_out_found_value_o(out_found), .res_out_chain_state_o(out_chain),
        .level_o(level), .stat_sel_i(stat_sel), .stat_cnt_o(stat_cnt),
        .stat_total_o(stat_total), .stat_clear_i(stat_clear)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        res_t head;
        head = '{out_key, out_value, out_opcode, out_rescode, out_bucket, out_found, out_chain};
        check("level", 128'(level), 128'(q.size()));
        check("in_ready", 128'(in_ready), 128'(q.size() != DEPTH));
        check("out_valid", 128'(out_valid), 128'(q.size() != 0));
        if (q.size() != 0) check("head", 128'(head), 128'(q[0]));
        check("stat_cnt", 128'(stat_cnt), 128'(stat_exp));
        check("stat_total", 128'(stat_total), 128'(tot_m));
    endtask

    // Apply the current inputs for one clock edge, advance the model, then compare.
    task automatic step();
        bit   do_push, do_pop;
        res_t cur;
        cur = '{in_key, in_value, in_opcode, in_rescode, in_bucket, in_found, in_chain};
        if (rst) begin
            q.delete();
            foreach (cnt_m[i]) cnt_m[i] = 0;
            tot_m = 0;
            stat_exp = 0;
        end else begin
            do_push = in_valid && (q.size() < DEPTH);
            do_pop  = out_ready && (q.size() > 0);
            stat_exp = cnt_m[stat_sel];
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(cur);
            if (stat_clear) begin
                foreach (cnt_m[i]) cnt_m[i] = 0;
                tot_m = 0;
            end else if (do_push) begin
                if (cnt_m[cur.rescode] < CMAX) cnt_m[cur.rescode]++;
                if (tot_m < CMAX) tot_m++;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input logic [31:0] key, input logic [2:0] rc);
        in_valid   = v;
        in_key     = key;
        in_rescode = rc;
        in_value   = $urandom;
        in_found   = $urandom;
        in_opcode  = 2'($urandom_range(0, 3));
        in_bucket  = 10'($urandom_range(0, 1023));
        in_chain   = 3'($urandom_range(0, 7));
    endtask

    initial begin
        foreach (cnt_m[i]) cnt_m[i] = 0;
        tot_m = 0;
        stat_exp = 0;
        @(negedge clk);

        // reset values
        rst = 1; step(); rst = 0;
        check("rst_ready", 128'(in_ready), 128'(1));

        // single pass
        out_ready = 1; stat_sel = 2;
        drive(1, 32'h11, 3'd2); step();
        check("sp_key", 128'(out_key), 128'(32'h11));
        drive(0, 0, 0); step(); step();
        check("sp_cnt", 128'(stat_cnt), 128'(1));

        // fill past full, then drain
        out_ready = 0;
        for (int i = 0; i < 20; i++) begin drive(1, 32'(i), 3'(i)); step(); end
        check("full_level", 128'(level), 128'(16));
        check("full_ready", 128'(in_ready), 128'(0));
        drive(0, 0, 0); out_ready = 1;
        for (int i = 0; i < 16; i++) begin check("drain_key", 128'(out_key), 128'(i)); step(); end
        check("drain_ready", 128'(in_ready), 128'(1));

        // sustained push/pop at level 5 across pointer wrap
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin drive(1, 32'(100 + i), 3'(i)); step(); end
        out_ready = 1;
        for (int i = 0; i < 100; i++) begin drive(1, 32'(200 + i), 3'($urandom_range(0, 7))); step(); end
        check("steady_level", 128'(level), 128'(5));
        drive(0, 0, 0);
        for (int i = 0; i < 5; i++) step();

        // saturation
        stat_clear = 1; step(); stat_clear = 0;
        stat_sel = 1;
        for (int i = 0; i < 20; i++) begin drive(1, 32'(i), 3'd1); step(); end
        drive(0, 0, 0); step();
        check("sat_cnt", 128'(stat_cnt), 128'(15));
        check("sat_total", 128'(stat_total), 128'(15));

        // clear wins over a simultaneous push
        out_ready = 0; stat_sel = 3;
        drive(1, 32'h33, 3'd3); stat_clear = 1; step();
        stat_clear = 0; drive(0, 0, 0); step();
        check("clr_cnt3", 128'(stat_cnt), 128'(0));
        check("clr_level", 128'(level), 128'(1));

        // reset mid-stream at level 7
        for (int i = 0; i < 6; i++) begin drive(1, 32'(i), 3'(i)); step(); end
        drive(0, 0, 0);
        check("pre_rst_level", 128'(level), 128'(7));
        rst = 1; step(); rst = 0;
        check("mid_rst_level", 128'(level), 128'(0));

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)));
            out_ready  = 1'($urandom_range(0, 2) != 0 ? (i % 400 < 200 ? 1 : $urandom_range(0, 1)) : 0);
            stat_sel   = 3'($urandom_range(0, 7));
            stat_clear = ($urandom_range(0, 40) == 0);
            rst        = ($urandom_range(0, 300) == 0);
            step();
        end
        rst = 0; stat_clear = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
